// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and ASCII constants for the UART transmit FIFO
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - simple dual-port RAM, one write port, one registered read port
module uart_fifo_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Write port: contents are never reset, the FIFO pointers define validity
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: one-cycle latency, output holds between reads
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit FIFO feeding uart_tx one byte per baud slot; UART_TX_FIFO_CRLF_EN expands LF to CR LF
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic                  baud_x1,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_strobe,
  input  logic                  tx_ready
);

  localparam logic [DEPTH_LOG2:0]   LEVEL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_accept;
  logic                  pop;
  tx_state_t             state;

`ifdef UART_TX_FIFO_CRLF_EN
  logic cr_pending;
`endif

  // Flags come from the registered level only, so a same-cycle pop never frees room for a write
  assign full      = (level == LEVEL_MAX);
  assign empty     = (level == '0);
  assign wr_accept = wr_en && !full && !reset;

  // Pop only from IDLE on a baud slot; a pending LF suppresses the pop so it is sent first
  always_comb begin
    pop = (state == ST_IDLE) && baud_x1 && !empty && tx_ready;
`ifdef UART_TX_FIFO_CRLF_EN
    if (cr_pending) pop = 1'b0;
`endif
  end

  uart_fifo_ram #(
    .ADDR_WIDTH (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (mclk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointer, occupancy and sticky overflow bookkeeping
  always_ff @(posedge mclk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)       rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_accept, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
      if (wr_en && full) overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

  // Send sequencer: IDLE pops, LOAD captures the RAM word, HOLD keeps the strobe for one baud slot, GAP lets tx_ready fall
  always_ff @(posedge mclk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tx_data   <= '0;
      tx_strobe <= 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_pending <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
`ifdef UART_TX_FIFO_CRLF_EN
          if (cr_pending && baud_x1 && tx_ready) state <= ST_LOAD;
          else if (pop)                          state <= ST_LOAD;
`else
          if (pop) state <= ST_LOAD;
`endif
        end
        ST_LOAD: begin
`ifdef UART_TX_FIFO_CRLF_EN
          if (cr_pending) begin
            tx_data    <= DATA_WIDTH'(ASCII_LF);
            cr_pending <= 1'b0;
          end else if (rd_data == DATA_WIDTH'(ASCII_LF)) begin
            tx_data    <= DATA_WIDTH'(ASCII_CR);
            cr_pending <= 1'b1;
          end else begin
            tx_data <= rd_data;
          end
`else
          tx_data <= rd_data;
`endif
          tx_strobe <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (baud_x1) begin
            tx_strobe <= 1'b0;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (baud_x1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
